// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS32 subset pipeline: opcodes, ALU/load
// selectors and the pipeline register layouts.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
    typedef enum logic [1:0] {LD_NONE, LD_WORD, LD_HALF, LD_HALFU} load_e;

    typedef struct packed {
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        alu_op_e     aluOp;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] storeData;
        logic [4:0]  destReg;
        logic        regWrite;
        load_e       loadKind;
        logic        memWrite;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic [4:0]  destReg;
        logic        regWrite;
        load_e       loadKind;
        logic        memWrite;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wbData;
        logic [4:0]  destReg;
        logic        regWrite;
    } mem_wb_t;

    function automatic logic [31:0] signExtend16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for the EX stage; slt compares as signed two's complement.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     aluOp_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = '0;
        case (aluOp_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mips5_pipeline_core.sv
// 5-stage MIPS32 subset core with no forwarding or stalls; software spaces dependent
// instructions with NOPs. Register file and byte-wide data memory live here.
module mips5_pipeline_core
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 256,
    parameter int DMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] next_instruction,
    output logic [31:0] alu_result,
    input  logic [7:0]  instruction_mem [IMEM_BYTES-1:0]
);

    localparam int IAW = $clog2(IMEM_BYTES);
    localparam int DAW = $clog2(DMEM_BYTES);

    logic [IAW-1:0] pc_q, pc_d;
    if_id_t         ifId_q, ifId_d;
    id_ex_t         idEx_q, idEx_d;
    ex_mem_t        exMem_q, exMem_d;
    mem_wb_t        memWb_q, memWb_d;
    logic [31:0]    regFile_q [32];
    logic [7:0]     dataMem_q [DMEM_BYTES];

    // Little-endian fetch; index arithmetic is IAW bits wide so it wraps with the PC.
    logic [IAW-1:0] fetchIdx1, fetchIdx2, fetchIdx3;
    assign fetchIdx1 = pc_q + IAW'(1);
    assign fetchIdx2 = pc_q + IAW'(2);
    assign fetchIdx3 = pc_q + IAW'(3);
    assign next_instruction = {instruction_mem[fetchIdx3], instruction_mem[fetchIdx2],
                               instruction_mem[fetchIdx1], instruction_mem[pc_q]};
    assign pc_d   = pc_q + IAW'(4);
    assign ifId_d = '{instr: next_instruction};

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, unusedShamt;
    logic [31:0] rsVal, rtVal, immExt;
    logic        rValid;
    alu_op_e     rAluOp;

    assign {opcode, rs, rt, rd, unusedShamt, funct} = ifId_q.instr;
    assign rsVal  = regFile_q[rs];
    assign rtVal  = regFile_q[rt];
    assign immExt = signExtend16(ifId_q.instr[15:0]);

    // Anything outside the supported subset leaves idEx_d all-zero, which is a bubble.
    always_comb begin
        idEx_d = '0;
        rValid = 1'b1;
        rAluOp = ALU_ADD;
        case (funct)
            FN_ADD:  rAluOp = ALU_ADD;
            FN_SUB:  rAluOp = ALU_SUB;
            FN_AND:  rAluOp = ALU_AND;
            FN_OR:   rAluOp = ALU_OR;
            FN_SLT:  rAluOp = ALU_SLT;
            default: rValid = 1'b0;
        endcase
        case (opcode)
            OP_RTYPE: if (rValid) begin
                idEx_d.aluOp    = rAluOp;
                idEx_d.a        = rsVal;
                idEx_d.b        = rtVal;
                idEx_d.destReg  = rd;
                idEx_d.regWrite = 1'b1;
            end
            OP_ADDI, OP_LW, OP_LH, OP_LHU: begin
                idEx_d.a        = rsVal;
                idEx_d.b        = immExt;
                idEx_d.destReg  = rt;
                idEx_d.regWrite = 1'b1;
                idEx_d.loadKind = (opcode == OP_LW)  ? LD_WORD :
                                  (opcode == OP_LH)  ? LD_HALF :
                                  (opcode == OP_LHU) ? LD_HALFU : LD_NONE;
            end
            OP_SW: begin
                idEx_d.a         = rsVal;
                idEx_d.b         = immExt;
                idEx_d.storeData = rtVal;
                idEx_d.memWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    logic [31:0] aluOut;

    mips_alu u_alu (
        .a_i      (idEx_q.a),
        .b_i      (idEx_q.b),
        .aluOp_i  (idEx_q.aluOp),
        .result_o (aluOut)
    );

    always_comb begin
        exMem_d           = '0;
        exMem_d.aluResult = aluOut;
        exMem_d.storeData = idEx_q.storeData;
        exMem_d.destReg   = idEx_q.destReg;
        exMem_d.regWrite  = idEx_q.regWrite;
        exMem_d.loadKind  = idEx_q.loadKind;
        exMem_d.memWrite  = idEx_q.memWrite;
    end

    assign alu_result = exMem_q.aluResult;

    logic [DAW-1:0] memAddr, memIdx1, memIdx2, memIdx3;
    logic [31:0]    loadWord;
    assign memAddr  = exMem_q.aluResult[DAW-1:0];
    assign memIdx1  = memAddr + DAW'(1);
    assign memIdx2  = memAddr + DAW'(2);
    assign memIdx3  = memAddr + DAW'(3);
    assign loadWord = {dataMem_q[memIdx3], dataMem_q[memIdx2],
                       dataMem_q[memIdx1], dataMem_q[memAddr]};

    always_comb begin
        memWb_d          = '0;
        memWb_d.destReg  = exMem_q.destReg;
        memWb_d.regWrite = exMem_q.regWrite;
        case (exMem_q.loadKind)
            LD_WORD:  memWb_d.wbData = loadWord;
            LD_HALF:  memWb_d.wbData = signExtend16(loadWord[15:0]);
            LD_HALFU: memWb_d.wbData = {16'b0, loadWord[15:0]};
            default:  memWb_d.wbData = exMem_q.aluResult;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            ifId_q  <= '0;
            idEx_q  <= '0;
            exMem_q <= '0;
            memWb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifId_q  <= ifId_d;
            idEx_q  <= idEx_d;
            exMem_q <= exMem_d;
            memWb_q <= memWb_d;
        end
    end

    // Architectural storage; $0 is kept zero by never writing it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regFile_q[i] <= '0;
            for (int i = 0; i < DMEM_BYTES; i++) dataMem_q[i] <= '0;
        end else begin
            if (exMem_q.memWrite) begin
                dataMem_q[memAddr] <= exMem_q.storeData[7:0];
                dataMem_q[memIdx1] <= exMem_q.storeData[15:8];
                dataMem_q[memIdx2] <= exMem_q.storeData[23:16];
                dataMem_q[memIdx3] <= exMem_q.storeData[31:24];
            end
            if (memWb_q.regWrite && memWb_q.destReg != 5'd0)
                regFile_q[memWb_q.destReg] <= memWb_q.wbData;
        end
    end

endmodule

// File: tb/tb_mips5_pipeline_core.sv
// Bench for mips5_pipeline_core: a directed program table, a mid-run reset sequence and
// random NOP-spaced programs checked against an instruction-level reference model.
module tb_mips5_pipeline_core;

    localparam int RUN_STEPS = 140;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] nextInstr;
    logic [31:0] aluRes;
    logic [7:0]  imem [255:0];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        bit          chk;
        logic [31:0] expAlu;
    } vec_t;

    vec_t        vecs [64];
    logic [31:0] mRegs [32];
    logic [7:0]  mMem [256];
    logic [31:0] expAlu [RUN_STEPS];
    bit          expValid [RUN_STEPS];

    mips5_pipeline_core #(.IMEM_BYTES(256), .DMEM_BYTES(256)) dut (
        .clk              (clk),
        .reset            (reset),
        .next_instruction (nextInstr),
        .alu_result       (aluRes),
        .instruction_mem  (imem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clearVecs();
        for (int i = 0; i < 64; i++) vecs[i] = '{32'h0, 1'b0, 32'h0};
    endtask

    task automatic setVec(input int idx, input logic [31:0] instr, input logic [31:0] exp);
        vecs[idx] = '{instr, 1'b1, exp};
    endtask

    task automatic applyStimulus();
        for (int w = 0; w < 64; w++)
            for (int k = 0; k < 4; k++)
                imem[4*w+k] = vecs[w].instr[8*k +: 8];
    endtask

    task automatic expFromVecs();
        for (int f = 0; f < RUN_STEPS; f++) begin
            expAlu[f]   = vecs[f % 64].expAlu;
            expValid[f] = vecs[f % 64].chk;
        end
    endtask

    task automatic resetDut(input string tag);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " reset alu"}, aluRes, 32'h0);
        checkOutput({tag, " reset fetch"}, nextInstr, vecs[0].instr);
        reset = 1'b0;
    endtask

    task automatic runCheck(input int steps, input string tag);
        for (int s = 1; s <= steps; s++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("%s fetch s=%0d", tag, s), nextInstr, vecs[s % 64].instr);
            if (s < 3)
                checkOutput($sformatf("%s flushed alu s=%0d", tag, s), aluRes, 32'h0);
            else if (expValid[s-3])
                checkOutput($sformatf("%s alu s=%0d", tag, s), aluRes, expAlu[s-3]);
        end
    endtask

    // Instruction-level reference: executes one word against mRegs/mMem in program order.
    task automatic modelExec(input logic [31:0] w, output bit isReal, output logic [31:0] res);
        logic [31:0] a, bv, se, val;
        logic [7:0]  ad;
        logic [4:0]  dst;
        bit          wr;
        a      = mRegs[w[25:21]];
        bv     = mRegs[w[20:16]];
        se     = {{16{w[15]}}, w[15:0]};
        isReal = 1'b0;
        wr     = 1'b0;
        val    = 32'h0;
        res    = 32'h0;
        dst    = w[20:16];
        if (w[31:26] == 6'h00) begin
            dst    = w[15:11];
            isReal = 1'b1;
            case (w[5:0])
                6'h20:   val = a + bv;
                6'h22:   val = a - bv;
                6'h24:   val = a & bv;
                6'h25:   val = a | bv;
                6'h2A:   val = ($signed(a) < $signed(bv)) ? 32'h1 : 32'h0;
                default: isReal = 1'b0;
            endcase
            wr  = isReal;
            res = val;
        end else begin
            res = a + se;
            ad  = res[7:0];
            isReal = 1'b1;
            case (w[31:26])
                6'h08: begin wr = 1'b1; val = res; end
                6'h23: begin
                    wr  = 1'b1;
                    val = {mMem[ad+8'd3], mMem[ad+8'd2], mMem[ad+8'd1], mMem[ad]};
                end
                6'h21: begin
                    wr  = 1'b1;
                    val = {{16{mMem[ad+8'd1][7]}}, mMem[ad+8'd1], mMem[ad]};
                end
                6'h25: begin
                    wr  = 1'b1;
                    val = {16'h0, mMem[ad+8'd1], mMem[ad]};
                end
                6'h2B: begin
                    mMem[ad]       = bv[7:0];
                    mMem[ad+8'd1]  = bv[15:8];
                    mMem[ad+8'd2]  = bv[23:16];
                    mMem[ad+8'd3]  = bv[31:24];
                end
                default: begin isReal = 1'b0; res = 32'h0; end
            endcase
        end
        if (wr && dst != 5'd0) mRegs[dst] = val;
    endtask

    function automatic logic [4:0] randReg();
        int r = $urandom_range(7, 15);
        return (r == 7) ? 5'd0 : 5'(r);
    endfunction

    function automatic logic [31:0] randInstr();
        logic [4:0]  rs  = randReg();
        logic [4:0]  rt  = randReg();
        logic [4:0]  rd  = randReg();
        logic [15:0] imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0:       return rType(rs, rt, rd, 6'h20);
            1:       return rType(rs, rt, rd, 6'h22);
            2:       return rType(rs, rt, rd, 6'h24);
            3:       return rType(rs, rt, rd, 6'h25);
            4:       return rType(rs, rt, rd, 6'h2A);
            5:       return iType(6'h08, rs, rt, imm);
            6:       return iType(6'h23, rs, rt, imm);
            7:       return iType(6'h21, rs, rt, imm);
            8:       return iType(6'h25, rs, rt, imm);
            default: return iType(6'h2B, rs, rt, imm);
        endcase
    endfunction

    initial begin
        bit          isReal;
        logic [31:0] res;
        reset = 1'b1;

        // Directed program; all-zero slots are NOPs, including the tail from word 48.
        clearVecs();
        setVec(0,  iType(6'h08, 5'd0, 5'd10, 16'd10), 32'd10);
        setVec(1,  iType(6'h08, 5'd0, 5'd12, 16'd11), 32'd11);
        setVec(5,  rType(5'd12, 5'd10, 5'd11, 6'h20), 32'd21);
        setVec(6,  rType(5'd12, 5'd10, 5'd13, 6'h22), 32'd1);
        setVec(7,  rType(5'd10, 5'd12, 5'd14, 6'h24), 32'd10);
        setVec(8,  rType(5'd12, 5'd10, 5'd15, 6'h25), 32'd11);
        setVec(9,  iType(6'h2B, 5'd10, 5'd11, 16'd0), 32'd10);
        setVec(13, iType(6'h23, 5'd10, 5'd16, 16'd0), 32'd10);
        setVec(14, iType(6'h08, 5'd0, 5'd19, 16'h7fff), 32'h0000_7fff);
        setVec(18, iType(6'h08, 5'd19, 5'd19, 16'h6000), 32'h0000_dfff);
        setVec(22, iType(6'h08, 5'd19, 5'd19, 16'h6000), 32'h0001_3fff);
        setVec(26, iType(6'h08, 5'd19, 5'd19, 16'h6000), 32'h0001_9fff);
        setVec(30, iType(6'h08, 5'd19, 5'd19, 16'h6000), 32'h0001_ffff);
        setVec(34, iType(6'h2B, 5'd10, 5'd19, 16'd0), 32'd10);
        setVec(35, rType(5'd16, 5'd0, 5'd20, 6'h20), 32'd21);
        setVec(38, iType(6'h21, 5'd10, 5'd17, 16'd0), 32'd10);
        setVec(39, iType(6'h25, 5'd10, 5'd18, 16'd0), 32'd10);
        setVec(40, iType(6'h08, 5'd0, 5'd0, 16'd5), 32'd5);
        setVec(43, rType(5'd17, 5'd0, 5'd21, 6'h20), 32'hffff_ffff);
        setVec(44, rType(5'd18, 5'd0, 5'd22, 6'h20), 32'h0000_ffff);
        setVec(45, rType(5'd0, 5'd0, 5'd23, 6'h20), 32'h0);
        setVec(46, rType(5'd17, 5'd10, 5'd24, 6'h2A), 32'h1);
        setVec(47, rType(5'd10, 5'd17, 5'd25, 6'h2A), 32'h0);
        applyStimulus();
        expFromVecs();
        resetDut("dir");
        checkOutput("dir fetch pc0", nextInstr, vecs[0].instr);
        runCheck(70, "dir");

        // Reset while the directed program is still running, then prove state was cleared.
        clearVecs();
        setVec(0, iType(6'h23, 5'd0, 5'd8, 16'd10), 32'd10);
        setVec(4, rType(5'd8, 5'd10, 5'd9, 6'h20), 32'h0);
        setVec(5, rType(5'd12, 5'd19, 5'd9, 6'h20), 32'h0);
        setVec(6, iType(6'h08, 5'd0, 5'd9, 16'hffff), 32'hffff_ffff);
        applyStimulus();
        expFromVecs();
        resetDut("mid");
        runCheck(12, "mid");

        for (int p = 0; p < 6; p++) begin
            clearVecs();
            for (int j = 0; j < 16; j++) vecs[4*j].instr = randInstr();
            for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
            for (int i = 0; i < 256; i++) mMem[i] = 8'h0;
            for (int f = 0; f < RUN_STEPS; f++) begin
                modelExec(vecs[f % 64].instr, isReal, res);
                expValid[f] = isReal;
                expAlu[f]   = res;
            end
            applyStimulus();
            resetDut($sformatf("rnd%0d", p));
            runCheck(RUN_STEPS, $sformatf("rnd%0d", p));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
